// File: rtl/inv_kin_sched.sv
// ---------------------------------------------------------------------------
// inv_kin_sched
//
// Purpose:
//   Two-requester front end for a single, non-pipelined inv_kin datapath
//   (x,y -> theta1,theta2, sign-magnitude Q16.15). Requests are arbitrated
//   round-robin. The winning operands are held on ik_x/ik_y for the whole
//   computation. The datapath is flushed once per job, and the captured
//   angles are returned on a valid/ready response channel. Targets whose
//   |x| or |y| exceeds REACH are rejected at once, without using the
//   datapath.
//
// Ports:
//   clock, rst                   system clock, synchronous active-high reset
//   req0_valid/ready/x/y         requester 0 job channel
//   req1_valid/ready/x/y         requester 1 job channel
//   ik_x, ik_y                   registered operands to the datapath
//   ik_flush                     datapath reset (rst or FLUSH state)
//   ik_theta1, ik_theta2         datapath results
//   rsp_valid/ready              response handshake
//   rsp_theta1/2, rsp_id, rsp_err  response payload
//   busy                         scheduler is not idle
// ---------------------------------------------------------------------------
module inv_kin_sched #(
    parameter int                   BIT_WIDTH = 32,
    parameter int                   LATENCY   = 40,
    parameter logic [BIT_WIDTH-1:0] REACH     = 32'h000B8000
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [BIT_WIDTH-1:0] req0_x,
    input  logic [BIT_WIDTH-1:0] req0_y,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [BIT_WIDTH-1:0] req1_x,
    input  logic [BIT_WIDTH-1:0] req1_y,
    output logic [BIT_WIDTH-1:0] ik_x,
    output logic [BIT_WIDTH-1:0] ik_y,
    output logic                 ik_flush,
    input  logic [BIT_WIDTH-1:0] ik_theta1,
    input  logic [BIT_WIDTH-1:0] ik_theta2,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BIT_WIDTH-1:0] rsp_theta1,
    output logic [BIT_WIDTH-1:0] rsp_theta2,
    output logic                 rsp_id,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [BIT_WIDTH-2:0] REACH_MAG = REACH[BIT_WIDTH-2:0];
    localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state;
    logic                 last_grant;
    logic [CNT_W-1:0]     counter;
    logic                 grant;
    logic                 accept;
    logic [BIT_WIDTH-1:0] sel_x;
    logic [BIT_WIDTH-1:0] sel_y;
    logic                 out_of_reach;

    // On contention the requester that did not win last time is granted.
    // Otherwise the only valid requester is granted. Ready is gated by
    // reset so that nothing is offered while the block is being cleared.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
        req0_ready   = (state == IDLE) && !rst && req0_valid && !grant;
        req1_ready   = (state == IDLE) && !rst && req1_valid && grant;
        accept       = req0_ready || req1_ready;
        sel_x        = grant ? req1_x : req0_x;
        sel_y        = grant ? req1_y : req0_y;
        out_of_reach = (sel_x[BIT_WIDTH-2:0] > REACH_MAG) ||
                       (sel_y[BIT_WIDTH-2:0] > REACH_MAG);
    end

    assign ik_flush  = rst || (state == FLUSH);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // Main scheduler. Operands and the response payload are registered here.
    // An accept only happens in IDLE, so a response handshake in RESP can
    // never overlap with a new acceptance.
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            counter    <= '0;
            ik_x       <= '0;
            ik_y       <= '0;
            rsp_theta1 <= '0;
            rsp_theta2 <= '0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ik_x       <= sel_x;
                        ik_y       <= sel_y;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        if (out_of_reach) begin
                            rsp_err    <= 1'b1;
                            rsp_theta1 <= '0;
                            rsp_theta2 <= '0;
                            state      <= RESP;
                        end else begin
                            state      <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    counter <= CNT_LOAD;
                    state   <= RUN;
                end
                RUN: begin
                    if (counter == '0) begin
                        rsp_theta1 <= ik_theta1;
                        rsp_theta2 <= ik_theta2;
                        rsp_err    <= 1'b0;
                        state      <= RESP;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_kin_sched.sv
// ---------------------------------------------------------------------------
// tb_inv_kin_sched
//
// Purpose:
//   Directed bench for inv_kin_sched. A stub datapath produces fixed angles
//   once LATENCY cycles have passed since the flush was released. Accepted
//   jobs push their expected response, along with its due cycle, into a
//   scoreboard queue. Responses are popped and compared on handshake.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_inv_kin_sched;

    localparam int          BW      = 32;
    localparam int          LAT     = 40;
    localparam logic [30:0] REACH_M = 31'h000B8000;
    localparam logic [31:0] T1_STUB = 32'h0000C90F;
    localparam logic [31:0] T2_STUB = 32'h00006487;

    logic          clock = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [BW-1:0] req0_x, req0_y, req1_x, req1_y;
    logic [BW-1:0] ik_x, ik_y, ik_theta1, ik_theta2;
    logic          ik_flush;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [BW-1:0] rsp_theta1, rsp_theta2;

    inv_kin_sched #(.BIT_WIDTH(BW), .LATENCY(LAT), .REACH(32'h000B8000)) dut (
        .clock      (clock),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .ik_x       (ik_x),
        .ik_y       (ik_y),
        .ik_flush   (ik_flush),
        .ik_theta1  (ik_theta1),
        .ik_theta2  (ik_theta2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_theta1 (rsp_theta1),
        .rsp_theta2 (rsp_theta2),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Datapath stub: it counts cycles since the flush was released. The
    // angles are valid only once LATENCY cycles of computation have passed,
    // and read as garbage before that.
    logic [7:0] stub_cnt;
    always_ff @(posedge clock) begin
        if (ik_flush) begin
            stub_cnt <= 8'd0;
        end else if (stub_cnt < 8'd200) begin
            stub_cnt <= stub_cnt + 8'd1;
        end
    end
    assign ik_theta1 = (!ik_flush && stub_cnt >= 8'(LAT - 1)) ? T1_STUB : 32'hDEADBEEF;
    assign ik_theta2 = (!ik_flush && stub_cnt >= 8'(LAT - 1)) ? T2_STUB : 32'hBADC0FFE;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } job_t;

    typedef struct {
        logic        id;
        logic        err;
        logic [31:0] t1;
        logic [31:0] t2;
        int          due;
    } exp_t;

    job_t        pend0[$];
    job_t        pend1[$];
    exp_t        sb[$];
    int          n_asserts = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          flushes   = 0;
    logic        model_last;
    logic        seen;
    logic        hold_chk;
    logic [31:0] exp_ikx, exp_iky;
    logic [31:0] snap_t1, snap_t2;
    logic        snap_id, snap_err;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive both requesters from the heads of their pending-job queues.
    task automatic applyStimulus();
        req0_valid = (pend0.size() > 0);
        req0_x     = (pend0.size() > 0) ? pend0[0].x : 32'd0;
        req0_y     = (pend0.size() > 0) ? pend0[0].y : 32'd0;
        req1_valid = (pend1.size() > 0);
        req1_x     = (pend1.size() > 0) ? pend1[0].x : 32'd0;
        req1_y     = (pend1.size() > 0) ? pend1[0].y : 32'd0;
    endtask

    // One clock cycle. Observe and check at the negedge, then let the
    // posedge happen, then update the drives 1 time unit later.
    task automatic step();
        logic        a0, a1, gid, exp_id, err;
        logic [30:0] mx, my;
        job_t        job;
        exp_t        e;
        @(negedge clock);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        if (rst) begin
            a0       = 1'b0;
            a1       = 1'b0;
            hold_chk = 1'b0;
            seen     = 1'b0;
        end else begin
            if (ik_flush) flushes++;
            checkOutput("single_grant", {31'd0, req0_ready & req1_ready}, 32'd0);
            checkOutput("ik_x_hold", ik_x, exp_ikx);
            checkOutput("ik_y_hold", ik_y, exp_iky);
            if (rsp_valid) checkOutput("ready_in_resp", {30'd0, req0_ready, req1_ready}, 32'd0);
            if (hold_chk) begin
                checkOutput("hold_valid", {31'd0, rsp_valid}, 32'd1);
                checkOutput("hold_theta1", rsp_theta1, snap_t1);
                checkOutput("hold_theta2", rsp_theta2, snap_t2);
                checkOutput("hold_id", {31'd0, rsp_id}, {31'd0, snap_id});
                checkOutput("hold_err", {31'd0, rsp_err}, {31'd0, snap_err});
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    if (!seen) begin
                        checkOutput("rsp_latency", cyc, sb[0].due);
                        seen = 1'b1;
                    end
                    if (rsp_ready) begin
                        e = sb.pop_front();
                        checkOutput("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        checkOutput("rsp_theta1", rsp_theta1, e.t1);
                        checkOutput("rsp_theta2", rsp_theta2, e.t2);
                        seen = 1'b0;
                    end
                end
            end
            hold_chk = rsp_valid && !rsp_ready;
            snap_t1  = rsp_theta1;
            snap_t2  = rsp_theta2;
            snap_id  = rsp_id;
            snap_err = rsp_err;
            if (a0 || a1) begin
                gid = a1;
                if (req0_valid && req1_valid) begin
                    exp_id = !model_last;
                    checkOutput("rr_grant", {31'd0, gid}, {31'd0, exp_id});
                end
                model_last = gid;
                job = gid ? pend1[0] : pend0[0];
                mx  = job.x[30:0];
                my  = job.y[30:0];
                err = (mx > REACH_M) || (my > REACH_M);
                e.id  = gid;
                e.err = err;
                e.t1  = err ? 32'd0 : T1_STUB;
                e.t2  = err ? 32'd0 : T2_STUB;
                e.due = cyc + (err ? 1 : LAT + 2);
                sb.push_back(e);
                exp_ikx = job.x;
                exp_iky = job.y;
            end
        end
        @(posedge clock);
        cyc++;
        #1;
        if (a0) void'(pend0.pop_front());
        if (a1) void'(pend1.pop_front());
        applyStimulus();
    endtask

    task automatic runUntilDone(input int budget);
        int n;
        n = 0;
        while ((sb.size() > 0 || pend0.size() > 0 || pend1.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        checkOutput("drain_in_budget", {31'd0, n < budget}, 32'd1);
    endtask

    // One reset cycle. The bench's model goes back to its reset view too.
    task automatic doReset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        model_last = 1'b1;
        exp_ikx    = 32'd0;
        exp_iky    = 32'd0;
        seen       = 1'b0;
        hold_chk   = 1'b0;
    endtask

    initial begin
        int f0, t;
        rst        = 1'b1;
        rsp_ready  = 1'b1;
        model_last = 1'b1;
        seen       = 1'b0;
        hold_chk   = 1'b0;
        exp_ikx    = 32'd0;
        exp_iky    = 32'd0;
        applyStimulus();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_flush", {31'd0, ik_flush}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_theta1", rsp_theta1, 32'd0);
        checkOutput("reset_ik_x", ik_x, 32'd0);
        rst = 1'b0;
        step();
        checkOutput("flush_released", {31'd0, ik_flush}, 32'd0);

        $display("[TB] single in-reach job");
        f0 = flushes;
        pend0.push_back('{x: 32'h00060000, y: 32'h00058000});
        applyStimulus();
        runUntilDone(200);
        checkOutput("one_flush_job", flushes - f0, 32'd1);

        $display("[TB] contention, four jobs per requester");
        doReset();
        f0 = flushes;
        for (int i = 0; i < 4; i++) begin
            pend0.push_back('{x: 32'h00010000 * (i + 1), y: 32'h00008000});
            pend1.push_back('{x: 32'h00008000, y: 32'h00010000 * (i + 2)});
        end
        applyStimulus();
        runUntilDone(600);
        checkOutput("flush_per_job", flushes - f0, 32'd8);

        $display("[TB] response backpressure");
        rsp_ready = 1'b0;
        pend0.push_back('{x: 32'h00020000, y: 32'h00030000});
        pend1.push_back('{x: 32'h00040000, y: 32'h00050000});
        applyStimulus();
        t = 0;
        while (!rsp_valid && t < 200) begin
            step();
            t++;
        end
        checkOutput("resp_reached", {31'd0, rsp_valid}, 32'd1);
        repeat (10) begin
            step();
            checkOutput("busy_in_resp", {31'd0, busy}, 32'd1);
        end
        rsp_ready = 1'b1;
        runUntilDone(300);

        $display("[TB] reach boundaries");
        f0 = flushes;
        pend1.push_back('{x: 32'h000C0000, y: 32'h00000000});
        applyStimulus();
        runUntilDone(50);
        checkOutput("no_flush_on_reject", flushes - f0, 32'd0);
        f0 = flushes;
        pend0.push_back('{x: 32'h800B8000, y: 32'h00000000});
        pend0.push_back('{x: 32'h000B8000, y: 32'h000B8001});
        pend0.push_back('{x: 32'h800B8001, y: 32'h00000000});
        applyStimulus();
        runUntilDone(300);
        checkOutput("flush_boundary", flushes - f0, 32'd1);

        $display("[TB] reset during RUN");
        pend0.push_back('{x: 32'h00030000, y: 32'h00030000});
        applyStimulus();
        repeat (15) step();
        checkOutput("busy_mid_run", {31'd0, busy}, 32'd1);
        doReset();
        checkOutput("idle_after_rst", {31'd0, busy}, 32'd0);
        repeat (60) step();
        pend1.push_back('{x: 32'h00050000, y: 32'h00010000});
        applyStimulus();
        runUntilDone(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
